// File: rtl/uart2stream.sv
// uart2stream: 8N1 UART bridge between a host serial link and the byte
// command stream. The RX path deserialises uart_rx into rx_data/rx_valid
// (the consumer is always ready). The TX path serialises the response
// stream (tx_data/tx_valid/tx_ready) onto uart_tx. Both directions use a
// fixed baud divider and run fully independently.
module uart2stream #(
   parameter int DIV = 48,            // clock cycles per UART bit
   parameter int CW  = $clog2(DIV)    // bit-timer width, derived from DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_err,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] TIMER_ONE   = CW'(1);

   // ---------------------------------------------------------------------
   // Receive path
   // ---------------------------------------------------------------------
   logic          rx_meta;
   logic          rxs;
   logic [1:0]    rx_state;
   logic [CW-1:0] rx_timer;
   logic [2:0]    rx_cnt;
   logic [7:0]    rx_shift;
   logic          rx_armed;   // line seen high since the last stop bit

   // Two-flop synchroniser on the asynchronous serial input, idle level 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every flop
         // samples the pre-edge value; blocking here would collapse the
         // two synchroniser stages into one.
         rx_meta <= uart_rx;
         rxs     <= rx_meta;
      end
   end

   // RX FSM: find the start edge, sample each bit at its centre, check stop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= ST_IDLE;
         rx_timer <= '0;
         rx_cnt   <= '0;
         rx_shift <= '0;
         rx_armed <= 1'b1;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         case (rx_state)
            ST_IDLE: begin
               // After a low stop bit (break) wait for the line to recover
               // before accepting another falling edge.
               if (rxs) begin
                  rx_armed <= 1'b1;
               end else if (rx_armed) begin
                  rx_timer <= HALF_RELOAD;
                  rx_state <= ST_START;
               end
            end
            ST_START: begin
               if (rx_timer != '0) begin
                  rx_timer <= rx_timer - TIMER_ONE;
               end else if (rxs) begin
                  rx_state <= ST_IDLE;              // glitch, not a start bit
               end else begin
                  rx_timer <= BIT_RELOAD;
                  rx_cnt   <= '0;
                  rx_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (rx_timer != '0) begin
                  rx_timer <= rx_timer - TIMER_ONE;
               end else begin
                  rx_shift <= {rxs, rx_shift[7:1]};  // LSB arrives first
                  rx_timer <= BIT_RELOAD;
                  if (rx_cnt == 3'd7) begin
                     rx_state <= ST_STOP;
                  end else begin
                     rx_cnt <= rx_cnt + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               if (rx_timer != '0) begin
                  rx_timer <= rx_timer - TIMER_ONE;
               end else begin
                  // Leave at mid-stop-bit so an immediately following start
                  // bit is still caught.
                  rx_state <= ST_IDLE;
                  if (rxs) begin
                     rx_data  <= rx_shift;
                     rx_valid <= 1'b1;
                  end else begin
                     rx_err   <= 1'b1;
                     rx_armed <= 1'b0;
                  end
               end
            end
            default: rx_state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Transmit path
   // ---------------------------------------------------------------------
   logic [1:0]    tx_state;
   logic [CW-1:0] tx_timer;
   logic [2:0]    tx_cnt;
   logic [7:0]    tx_shift;

   // Ready exactly while the transmitter sits in IDLE.
   assign tx_ready = (tx_state == ST_IDLE);

   // TX FSM: start bit, eight data bits LSB first, stop bit, DIV clk each.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= ST_IDLE;
         tx_timer <= '0;
         tx_cnt   <= '0;
         tx_shift <= '0;
         uart_tx  <= 1'b1;
      end else begin
         case (tx_state)
            ST_IDLE: begin
               if (tx_valid) begin
                  tx_shift <= tx_data;
                  tx_timer <= BIT_RELOAD;
                  uart_tx  <= 1'b0;
                  tx_state <= ST_START;
               end
            end
            ST_START: begin
               if (tx_timer != '0) begin
                  tx_timer <= tx_timer - TIMER_ONE;
               end else begin
                  uart_tx  <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_timer <= BIT_RELOAD;
                  tx_cnt   <= '0;
                  tx_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tx_timer != '0) begin
                  tx_timer <= tx_timer - TIMER_ONE;
               end else begin
                  tx_timer <= BIT_RELOAD;
                  if (tx_cnt == 3'd7) begin
                     uart_tx  <= 1'b1;
                     tx_state <= ST_STOP;
                  end else begin
                     uart_tx  <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_cnt   <= tx_cnt + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               if (tx_timer != '0) begin
                  tx_timer <= tx_timer - TIMER_ONE;
               end else begin
                  tx_state <= ST_IDLE;
               end
            end
            default: tx_state <= ST_IDLE;
         endcase
      end
   end

endmodule
